prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter IMEM_DEPTH, default 512: instruction memory depth in 32-bit words.
REQ-002 Parameter DMEM_DEPTH, default 1024: data memory depth in 64-bit words.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 arst_n  input  1  reset; synchronous, active-high (1 = reset).
REQ-005 rx_valid  input  1  byte-stream valid.
REQ-006 rx_data  input  8  byte-stream data.
REQ-007 rx_ready  output  1  byte accepted when rx_valid & rx_ready.
REQ-008 addr_ext  output  64  instruction memory byte address.
REQ-009 wen_ext  output  1  instruction memory write strobe, one cycle per word.
REQ-010 ren_ext  output  1  tied 0.
REQ-011 wdata_ext  output  32  instruction word.
REQ-012 addr_ext_2  output  64  data memory byte address.
REQ-013 wen_ext_2  output  1  data memory write strobe, one cycle per word.
REQ-014 ren_ext_2  output  1  tied 0.
REQ-015 wdata_ext_2  output  64  data word.
REQ-016 enable  output  1  CPU run enable.
REQ-017 busy  output  1  high whenever state != IDLE.
REQ-018 err  output  1  one-cycle error pulse.

Function
REQ-019 Frame format: CMD byte, BASE[15:0] little-endian (word index), COUNT[15:0] little-endian, then COUNT words, bytes little-endian (4 per IMEM word, 8 per DMEM word).
REQ-020 CMD 0xA0 = load IMEM, 0xA1 = load DMEM, 0xA5 = start (single byte, no header), 0xAF = stop (single byte).
REQ-021 FSM states: IDLE, HDR (4 header bytes), DATA (collect word bytes), WRITE (issue strobe), DONE.
REQ-022 IDLE -> HDR on 0xA0/0xA1; HDR -> DATA after 4th header byte if COUNT != 0, else -> DONE.
REQ-023 DATA -> WRITE on last byte of a word; WRITE lasts exactly 1 cycle, then DATA if words remain, else DONE; DONE lasts 1 cycle -> IDLE.
REQ-024 rx_ready = 1 in IDLE, HDR, DATA; 0 in WRITE and DONE.
REQ-025 Word k of a frame written to byte address (BASE+k)*4 (IMEM) or (BASE+k)*8 (DMEM); address held stable during strobe cycle.
REQ-026 Strobe and data registered: wen_ext/wen_ext_2 high only in WRITE, only for the selected memory.
REQ-027 Word index BASE+k >= depth: strobe suppressed, payload still consumed, err pulses in DONE.
REQ-028 0xA5 in IDLE: enable set next cycle, held until 0xAF or reset; 0xAF clears enable next cycle.
REQ-029 0xA0/0xA1 received while enable = 1: rejected, err pulses one cycle, stay IDLE.
REQ-030 Unknown CMD in IDLE: byte discarded, err pulses one cycle, stay IDLE.
REQ-031 Byte counter and word counter 16-bit; no wrap allowed, since COUNT <= 65535 fits the counter.
REQ-032 rx_valid low mid-frame: FSM holds state indefinitely, no timeout.

Reset
REQ-033 arst_n = 1 at a clock edge: state IDLE, counters 0, all outputs 0 (enable 0, strobes 0, addresses 0, data 0).
REQ-034 Reset mid-frame aborts frame; no strobe issued in the reset cycle or after; partially assembled word discarded.

Structure
REQ-035 Command byte codes, state encoding and byte-per-word constants belong in shared package loader_pkg.
REQ-036 One sub-module, byte_assembler: shifts in bytes LSB-first, outputs 64-bit word plus word-complete flag for 4- or 8-byte mode.

Verification
REQ-037 A0 00 00 02 00 + 13 00 00 00 + 93 00 10 00 -> wen_ext pulses twice: addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093; err 0.
REQ-038 A1 03 00 01 00 + bytes 01..08 -> single wen_ext_2 at addr 0x18, data 0x0807060504030201.
REQ-039 A0 FF 01 02 00 + 8 bytes (IMEM_DEPTH 512) -> one write at addr 0x7FC, second suppressed, err pulse in DONE.
REQ-040 A5 then A0 -> enable rises one cycle after A5; A0 gives err pulse, no strobe; AF -> enable falls.
REQ-041 A0 00 00 00 00 -> no strobe, DONE then IDLE, busy low after; byte 0x55 in IDLE -> err pulse.
REQ-042 arst_n asserted after 2 of 4 data bytes -> no strobe; next frame loads from byte 0 correctly.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared constants for the program loader: command codes, FSM encoding and
// per-memory word sizes.
package loader_pkg;

    localparam logic [7:0] CMD_LOAD_IMEM = 8'hA0;
    localparam logic [7:0] CMD_LOAD_DMEM = 8'hA1;
    localparam logic [7:0] CMD_START     = 8'hA5;
    localparam logic [7:0] CMD_STOP      = 8'hAF;

    localparam int HDR_BYTES            = 4;
    localparam int IMEM_BYTES_PER_WORD  = 4;
    localparam int DMEM_BYTES_PER_WORD  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Index of the final byte of a word: 3 for IMEM words, 7 for DMEM words.
    function automatic logic [2:0] last_byte_idx(input logic mode8);
        return mode8 ? 3'(DMEM_BYTES_PER_WORD - 1) : 3'(IMEM_BYTES_PER_WORD - 1);
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Collects a little-endian byte stream into 32- or 64-bit words. The word
// output already includes the byte being accepted this cycle, so the caller
// can register the complete word on the same edge the last byte arrives.
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        i_srst,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    input  logic        i_mode8,
    output logic [63:0] o_word,
    output logic        o_complete
);

    logic [2:0]  r_cnt;
    logic [63:0] r_word;
    logic        w_last;

    assign w_last     = (r_cnt == last_byte_idx(i_mode8));
    assign o_complete = i_valid && w_last;

    // Present each byte lane, bypassing the incoming byte into its lane.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign o_word[gi*8 +: 8] = (i_valid && (r_cnt == 3'(gi))) ? i_data
                                                                      : r_word[gi*8 +: 8];
        end
    endgenerate

    // Lane store and byte position; position returns to 0 after the last byte.
    always_ff @(posedge clk) begin
        if (i_srst || i_clear) begin
            r_cnt  <= 3'd0;
            r_word <= 64'd0;
        end else if (i_valid) begin
            for (int i = 0; i < 8; i++) begin
                if (r_cnt == 3'(i)) begin
                    r_word[i*8 +: 8] <= i_data;
                end
            end
            r_cnt <= w_last ? 3'd0 : r_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses load/start/stop commands and writes
// instruction and data memories one word per strobe.
module prog_loader
    import loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    output logic        enable,
    output logic        busy,
    output logic        err
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_DEPTH);
    localparam logic [31:0] DMEM_LIMIT = 32'(DMEM_DEPTH);

    state_t      r_state,    w_state_next;
    logic [1:0]  r_hdr_cnt,  w_hdr_cnt_next;
    logic [15:0] r_base,     w_base_next;
    logic [15:0] r_count,    w_count_next;
    logic [15:0] r_word_cnt, w_word_cnt_next;
    logic        r_dmem,     w_dmem_next;
    logic        r_ovf,      w_ovf_next;
    logic        r_enable,   w_enable_next;
    logic        r_err,      w_err_next;
    logic        r_wen,      w_wen_next;
    logic        r_wen2,     w_wen2_next;
    logic [63:0] r_addr,     w_addr_next;
    logic [63:0] r_addr2,    w_addr2_next;
    logic [31:0] r_wdata,    w_wdata_next;
    logic [63:0] r_wdata2,   w_wdata2_next;

    logic        w_accept;
    logic        w_asm_clear;
    logic        w_asm_valid;
    logic [63:0] w_word;
    logic        w_word_done;
    logic [16:0] w_idx;
    logic [15:0] w_hdr_count;

    assign rx_ready    = (r_state == ST_IDLE) || (r_state == ST_HDR) || (r_state == ST_DATA);
    assign w_accept    = rx_valid && rx_ready;
    assign w_asm_valid = w_accept && (r_state == ST_DATA);
    // Word index is 17 bits so BASE+k never wraps back into range.
    assign w_idx       = {1'b0, r_base} + {1'b0, r_word_cnt};
    assign w_hdr_count = {rx_data, r_count[7:0]};

    byte_assembler u_asm (
        .clk        (clk),
        .i_srst     (arst_n),
        .i_clear    (w_asm_clear),
        .i_valid    (w_asm_valid),
        .i_data     (rx_data),
        .i_mode8    (r_dmem),
        .o_word     (w_word),
        .o_complete (w_word_done)
    );

    // Next-state and next-output decode for the frame parser.
    always_comb begin
        w_state_next    = r_state;
        w_hdr_cnt_next  = r_hdr_cnt;
        w_base_next     = r_base;
        w_count_next    = r_count;
        w_word_cnt_next = r_word_cnt;
        w_dmem_next     = r_dmem;
        w_ovf_next      = r_ovf;
        w_enable_next   = r_enable;
        w_err_next      = 1'b0;
        w_wen_next      = 1'b0;
        w_wen2_next     = 1'b0;
        w_addr_next     = r_addr;
        w_addr2_next    = r_addr2;
        w_wdata_next    = r_wdata;
        w_wdata2_next   = r_wdata2;
        w_asm_clear     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (rx_data)
                        CMD_LOAD_IMEM, CMD_LOAD_DMEM: begin
                            if (r_enable) begin
                                // Never reload memories under a running CPU.
                                w_err_next = 1'b1;
                            end else begin
                                w_state_next    = ST_HDR;
                                w_dmem_next     = (rx_data == CMD_LOAD_DMEM);
                                w_hdr_cnt_next  = 2'd0;
                                w_word_cnt_next = 16'd0;
                                w_ovf_next      = 1'b0;
                                w_asm_clear     = 1'b1;
                            end
                        end
                        CMD_START: w_enable_next = 1'b1;
                        CMD_STOP:  w_enable_next = 1'b0;
                        default:   w_err_next    = 1'b1;
                    endcase
                end
            end
            ST_HDR: begin
                if (w_accept) begin
                    w_hdr_cnt_next = r_hdr_cnt + 2'd1;
                    case (r_hdr_cnt)
                        2'd0: w_base_next[7:0]   = rx_data;
                        2'd1: w_base_next[15:8]  = rx_data;
                        2'd2: w_count_next[7:0]  = rx_data;
                        default: begin
                            w_count_next[15:8] = rx_data;
                            w_state_next = (w_hdr_count != 16'd0) ? ST_DATA : ST_DONE;
                        end
                    endcase
                end
            end
            ST_DATA: begin
                if (w_word_done) begin
                    w_state_next    = ST_WRITE;
                    w_word_cnt_next = r_word_cnt + 16'd1;
                    if (r_dmem) begin
                        if (32'(w_idx) < DMEM_LIMIT) begin
                            w_wen2_next   = 1'b1;
                            w_addr2_next  = {44'd0, w_idx, 3'b000};
                            w_wdata2_next = w_word;
                        end else begin
                            w_ovf_next = 1'b1;
                        end
                    end else begin
                        if (32'(w_idx) < IMEM_LIMIT) begin
                            w_wen_next   = 1'b1;
                            w_addr_next  = {45'd0, w_idx, 2'b00};
                            w_wdata_next = w_word[31:0];
                        end else begin
                            w_ovf_next = 1'b1;
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (r_word_cnt == r_count) begin
                    w_state_next = ST_DONE;
                    // Out-of-range words are reported while DONE is showing.
                    w_err_next   = r_ovf;
                end else begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State and output registers; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (arst_n) begin
            r_state    <= ST_IDLE;
            r_hdr_cnt  <= 2'd0;
            r_base     <= 16'd0;
            r_count    <= 16'd0;
            r_word_cnt <= 16'd0;
            r_dmem     <= 1'b0;
            r_ovf      <= 1'b0;
            r_enable   <= 1'b0;
            r_err      <= 1'b0;
            r_wen      <= 1'b0;
            r_wen2     <= 1'b0;
            r_addr     <= 64'd0;
            r_addr2    <= 64'd0;
            r_wdata    <= 32'd0;
            r_wdata2   <= 64'd0;
        end else begin
            r_state    <= w_state_next;
            r_hdr_cnt  <= w_hdr_cnt_next;
            r_base     <= w_base_next;
            r_count    <= w_count_next;
            r_word_cnt <= w_word_cnt_next;
            r_dmem     <= w_dmem_next;
            r_ovf      <= w_ovf_next;
            r_enable   <= w_enable_next;
            r_err      <= w_err_next;
            r_wen      <= w_wen_next;
            r_wen2     <= w_wen2_next;
            r_addr     <= w_addr_next;
            r_addr2    <= w_addr2_next;
            r_wdata    <= w_wdata_next;
            r_wdata2   <= w_wdata2_next;
        end
    end

    assign addr_ext    = r_addr;
    assign wen_ext     = r_wen;
    assign ren_ext     = 1'b0;
    assign wdata_ext   = r_wdata;
    assign addr_ext_2  = r_addr2;
    assign wen_ext_2   = r_wen2;
    assign ren_ext_2   = 1'b0;
    assign wdata_ext_2 = r_wdata2;
    assign enable      = r_enable;
    assign busy        = (r_state != ST_IDLE);
    assign err         = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a frame-level model predicts memory writes,
// error pulses and run-enable; a monitor checks every strobe cycle.
module tb_prog_loader;

    localparam int IMEM_D = 512;
    localparam int DMEM_D = 1024;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic        enable;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    prog_loader #(.IMEM_DEPTH(IMEM_D), .DMEM_DEPTH(DMEM_D)) dut (
        .clk(clk), .arst_n(arst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .addr_ext(addr_ext), .wen_ext(wen_ext),
        .ren_ext(ren_ext), .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2),
        .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2),
        .enable(enable), .busy(busy), .err(err)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    int  vectors = 0;
    int  miscompares = 0;
    wr_t exp_imem[$];
    wr_t exp_dmem[$];
    wr_t obs_imem[$];
    wr_t obs_dmem[$];
    int  exp_err = 0;
    int  err_seen = 0;
    bit  m_enable = 0;
    logic [7:0] frm[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: what the memories must receive and how many errors.
    task automatic model_frame(input logic [7:0] f[$]);
        int base, cnt, bpw, depth, idx;
        logic [63:0] w;
        bit ovf;
        if (f[0] == 8'hA5) m_enable = 1;
        else if (f[0] == 8'hAF) m_enable = 0;
        else if (f[0] == 8'hA0 || f[0] == 8'hA1) begin
            if (m_enable) exp_err++;
            else begin
                base  = int'(f[1]) + 256 * int'(f[2]);
                cnt   = int'(f[3]) + 256 * int'(f[4]);
                bpw   = (f[0] == 8'hA1) ? 8 : 4;
                depth = (f[0] == 8'hA1) ? DMEM_D : IMEM_D;
                ovf   = 0;
                for (int k = 0; k < cnt; k++) begin
                    w = 64'd0;
                    for (int b = 0; b < bpw; b++)
                        w = w | (64'(f[5 + k*bpw + b]) << (8*b));
                    idx = base + k;
                    if (idx < depth) begin
                        if (bpw == 8) exp_dmem.push_back('{64'(idx*8), w});
                        else          exp_imem.push_back('{64'(idx*4), w});
                    end else ovf = 1;
                end
                if (ovf) exp_err++;
            end
        end else exp_err++;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            chk("rx_ready_timeout", 64'(rx_ready), 64'd1);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle_and_check(input string name);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle"}, 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        chk({name, "_imem_left"}, 64'(exp_imem.size()), 64'd0);
        chk({name, "_dmem_left"}, 64'(exp_dmem.size()), 64'd0);
        chk({name, "_err_count"}, 64'(err_seen), 64'(exp_err));
        chk({name, "_enable"}, 64'(enable), 64'(m_enable));
        $display("frame %s done: imem_writes=%0d dmem_writes=%0d errs=%0d enable=%0b",
                 name, obs_imem.size(), obs_dmem.size(), err_seen, enable);
    endtask

    task automatic run_frame(input string name, input int gap);
        model_frame(frm);
        foreach (frm[i]) send_byte(frm[i], gap);
        wait_idle_and_check(name);
    endtask

    // Monitor: every strobe is checked against the model's expected writes.
    always @(negedge clk) begin
        if (!arst_n) begin
            if (wen_ext || wen_ext_2) begin
                chk("strobe_ready_low", 64'(rx_ready), 64'd0);
                chk("strobe_exclusive", 64'(wen_ext && wen_ext_2), 64'd0);
                chk("ren_tied", 64'({ren_ext, ren_ext_2}), 64'd0);
            end
            if (wen_ext) begin
                obs_imem.push_back('{addr_ext, 64'(wdata_ext)});
                chk("imem_expected", 64'(exp_imem.size() != 0), 64'd1);
                if (exp_imem.size() != 0) begin
                    chk("imem_addr", addr_ext, exp_imem[0].addr);
                    chk("imem_data", 64'(wdata_ext), exp_imem[0].data);
                    void'(exp_imem.pop_front());
                end
            end
            if (wen_ext_2) begin
                obs_dmem.push_back('{addr_ext_2, wdata_ext_2});
                chk("dmem_expected", 64'(exp_dmem.size() != 0), 64'd1);
                if (exp_dmem.size() != 0) begin
                    chk("dmem_addr", addr_ext_2, exp_dmem[0].addr);
                    chk("dmem_data", wdata_ext_2, exp_dmem[0].data);
                    void'(exp_dmem.pop_front());
                end
            end
            if (err) err_seen++;
        end
    end

    initial begin
        arst_n   = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enable", 64'(enable), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_wen", 64'({wen_ext, wen_ext_2}), 64'd0);
        chk("rst_addr", addr_ext | addr_ext_2, 64'd0);
        chk("rst_wdata", 64'(wdata_ext) | wdata_ext_2, 64'd0);
        chk("rst_ready", 64'(rx_ready), 64'd1);
        @(negedge clk);
        arst_n = 1'b0;

        // Two IMEM words from address 0.
        frm = {8'hA0, 8'h00, 8'h00, 8'h02, 8'h00,
               8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_frame("imem2", 0);
        chk("imem2_n", 64'(obs_imem.size()), 64'd2);
        if (obs_imem.size() == 2) begin
            chk("imem2_a0", obs_imem[0].addr, 64'h0);
            chk("imem2_d0", obs_imem[0].data, 64'h0000_0013);
            chk("imem2_a1", obs_imem[1].addr, 64'h4);
            chk("imem2_d1", obs_imem[1].data, 64'h0010_0093);
        end
        obs_imem.delete();

        // One DMEM word at word index 3, with idle gaps between bytes.
        frm = {8'hA1, 8'h03, 8'h00, 8'h01, 8'h00,
               8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_frame("dmem1", 2);
        chk("dmem1_n", 64'(obs_dmem.size()), 64'd1);
        if (obs_dmem.size() == 1) begin
            chk("dmem1_a", obs_dmem[0].addr, 64'h18);
            chk("dmem1_d", obs_dmem[0].data, 64'h0807_0605_0403_0201);
        end
        obs_dmem.delete();

        // IMEM frame straddling the top of memory.
        frm = {8'hA0, 8'hFF, 8'h01, 8'h02, 8'h00,
               8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44, 8'h33, 8'h22, 8'h11};
        run_frame("imem_ovf", 0);
        chk("imem_ovf_n", 64'(obs_imem.size()), 64'd1);
        if (obs_imem.size() == 1) begin
            chk("imem_ovf_a", obs_imem[0].addr, 64'h7FC);
            chk("imem_ovf_d", obs_imem[0].data, 64'hAABB_CCDD);
        end
        chk("imem_ovf_errs", 64'(err_seen), 64'd1);
        obs_imem.delete();

        // DMEM frame straddling the top of memory.
        frm = {8'hA1, 8'hFF, 8'h03, 8'h02, 8'h00};
        for (int i = 0; i < 16; i++) frm.push_back(8'(8'h30 + i));
        run_frame("dmem_ovf", 1);
        chk("dmem_ovf_n", 64'(obs_dmem.size()), 64'd1);
        obs_dmem.delete();

        // Start, rejected load, stop.
        chk("pre_start_enable", 64'(enable), 64'd0);
        frm = {8'hA5};
        model_frame(frm);
        send_byte(8'hA5, 0);
        chk("start_enable", 64'(enable), 64'd1);
        frm = {8'hA0};
        model_frame(frm);
        send_byte(8'hA0, 0);
        chk("reject_err", 64'(err), 64'd1);
        chk("reject_busy", 64'(busy), 64'd0);
        frm = {8'hAF};
        run_frame("stop", 0);
        chk("stop_enable", 64'(enable), 64'd0);

        // Zero-length frame passes through DONE, then an unknown byte.
        frm = {8'hA0, 8'h00, 8'h00, 8'h00, 8'h00};
        model_frame(frm);
        foreach (frm[i]) send_byte(frm[i], 0);
        chk("zero_done_busy", 64'(busy), 64'd1);
        chk("zero_done_ready", 64'(rx_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("zero_idle_busy", 64'(busy), 64'd0);
        frm = {8'h55};
        run_frame("unknown", 0);

        // Reset after two data bytes, then a clean reload.
        frm = {8'hA0, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
        foreach (frm[i]) send_byte(frm[i], 0);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_wen", 64'(wen_ext), 64'd0);
        chk("abort_addr", addr_ext, 64'd0);
        @(negedge clk);
        arst_n = 1'b0;
        frm = {8'hA0, 8'h05, 8'h00, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_frame("reload", 0);
        chk("reload_n", 64'(obs_imem.size()), 64'd1);
        if (obs_imem.size() == 1) begin
            chk("reload_a", obs_imem[0].addr, 64'h14);
            chk("reload_d", obs_imem[0].data, 64'hDEAD_BEEF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
